// File: rtl/issue_ctrl.sv
// Dual-issue front-end: circular instruction queue feeding two decode slots, issuing 0/1/2 per cycle.
// Latency: queue head visible 1 cycle after push; issued slots registered 1 cycle after the issue decision.
// Backpressure: iq_ready drops below 2 free entries (fetch must hold); id_stall freezes outputs and pops. Optional ISSUE_PERF_CNT_EN adds perf counters.
module issue_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        id_stall,
    input  logic [1:0]  if_valid,
    input  logic [31:0] if_pc0,
    input  logic [31:0] if_pc1,
    input  logic [31:0] if_inst0,
    input  logic [31:0] if_inst1,
    output logic        iq_ready,
    output logic [1:0]  q_valid,
    output logic [31:0] q_inst0,
    output logic [31:0] q_inst1,
    input  logic        s0_w_reg_ena,
    input  logic        s1_w_reg_ena,
    input  logic [4:0]  s0_w_reg_dst,
    input  logic [4:0]  s1_rs,
    input  logic [4:0]  s1_rt,
    input  logic [4:0]  s1_w_reg_dst,
    input  logic        s0_is_bj,
    input  logic        s1_is_bj,
    input  logic        s0_is_ls,
    input  logic        s1_is_ls,
    input  logic        s0_is_hm,
    input  logic        s1_is_hm,
    input  logic        s0_is_single,
    input  logic        s1_is_single,
    output logic [1:0]  o_valid,
    output logic [31:0] o_pc0,
    output logic [31:0] o_pc1,
    output logic [31:0] o_inst0,
    output logic [31:0] o_inst1,
    output logic [31:0] perf_dual_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr1;
    logic [PW-1:0] wr_ptr1;

    logic [1:0]    o_valid_q;
    logic [31:0]   o_pc0_q, o_pc1_q, o_inst0_q, o_inst1_q;

    logic          push0, push1;
    logic [1:0]    push_n;
    logic [1:0]    issue_n;
    logic          slot1_blk;
    logic          raw_hz, waw_hz;

    assign rd_ptr1 = rd_ptr_q + PW'(1);
    assign wr_ptr1 = wr_ptr_q + PW'(1);

    // Ready is derived from registered count only, so fetch never sees a combinational path from decode.
    assign iq_ready   = (count_q <= CW'(DEPTH - 2));
    assign q_valid[0] = (count_q != '0);
    assign q_valid[1] = (count_q > CW'(1));
    assign q_inst0    = inst_mem[rd_ptr_q];
    assign q_inst1    = inst_mem[rd_ptr1];

    assign push0  = iq_ready & if_valid[0] & ~flush;
    assign push1  = iq_ready & (if_valid == 2'b11) & ~flush;
    assign push_n = {1'b0, push0} + {1'b0, push1};

    assign raw_hz = s0_w_reg_ena & ((s0_w_reg_dst == s1_rs) | (s0_w_reg_dst == s1_rt));
    assign waw_hz = s0_w_reg_ena & s1_w_reg_ena & (s0_w_reg_dst == s1_w_reg_dst);

    always_comb begin
        slot1_blk = ~q_valid[1] | s1_is_bj | s0_is_single | s1_is_single
                  | (s0_is_ls & s1_is_ls) | (s0_is_hm & s1_is_hm) | raw_hz | waw_hz;
        issue_n = 2'd0;
        // A branch at the head is held until its delay slot is in the queue.
        if (!id_stall && !flush && q_valid[0] && !(s0_is_bj && !q_valid[1])) begin
            issue_n = slot1_blk ? 2'd1 : 2'd2;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(issue_n);
        wr_ptr_d = wr_ptr_q + PW'(push_n);
        count_d  = count_q + CW'(push_n) - CW'(issue_n);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            pc_mem[wr_ptr_q]   <= if_pc0;
            inst_mem[wr_ptr_q] <= if_inst0;
        end
        if (push1) begin
            pc_mem[wr_ptr1]    <= if_pc1;
            inst_mem[wr_ptr1]  <= if_inst1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            o_valid_q <= 2'b00;
            o_pc0_q   <= '0;
            o_pc1_q   <= '0;
            o_inst0_q <= '0;
            o_inst1_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (flush) begin
                o_valid_q <= 2'b00;
            end else if (!id_stall) begin
                o_valid_q <= {issue_n == 2'd2, issue_n != 2'd0};
                // Slots that do not issue keep their old payload; only the valid bit drops.
                if (issue_n != 2'd0) begin
                    o_pc0_q   <= pc_mem[rd_ptr_q];
                    o_inst0_q <= inst_mem[rd_ptr_q];
                end
                if (issue_n == 2'd2) begin
                    o_pc1_q   <= pc_mem[rd_ptr1];
                    o_inst1_q <= inst_mem[rd_ptr1];
                end
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_pc0   = o_pc0_q;
    assign o_pc1   = o_pc1_q;
    assign o_inst0 = o_inst0_q;
    assign o_inst1 = o_inst1_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] perf_dual_q, perf_stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_dual_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue_n == 2'd2) begin
                perf_dual_q <= perf_dual_q + 32'd1;
            end
            if (q_valid[0] && !id_stall && !flush && issue_n == 2'd0) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_dual_cnt  = perf_dual_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_dual_cnt  = 32'd0;
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: a reference queue predicts each cycle's issue and output registers.
module tb_issue_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush, id_stall;
    logic [1:0]  if_valid;
    logic [31:0] if_pc0, if_pc1, if_inst0, if_inst1;
    logic        iq_ready;
    logic [1:0]  q_valid;
    logic [31:0] q_inst0, q_inst1;
    logic        s0_w_reg_ena, s1_w_reg_ena;
    logic [4:0]  s0_w_reg_dst, s1_rs, s1_rt, s1_w_reg_dst;
    logic        s0_is_bj, s1_is_bj, s0_is_ls, s1_is_ls, s0_is_hm, s1_is_hm;
    logic        s0_is_single, s1_is_single;
    logic [1:0]  o_valid;
    logic [31:0] o_pc0, o_pc1, o_inst0, o_inst1;
    logic [31:0] perf_dual_cnt, perf_stall_cnt;

    issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .id_stall(id_stall),
        .if_valid(if_valid), .if_pc0(if_pc0), .if_pc1(if_pc1),
        .if_inst0(if_inst0), .if_inst1(if_inst1),
        .iq_ready(iq_ready), .q_valid(q_valid), .q_inst0(q_inst0), .q_inst1(q_inst1),
        .s0_w_reg_ena(s0_w_reg_ena), .s1_w_reg_ena(s1_w_reg_ena),
        .s0_w_reg_dst(s0_w_reg_dst), .s1_rs(s1_rs), .s1_rt(s1_rt), .s1_w_reg_dst(s1_w_reg_dst),
        .s0_is_bj(s0_is_bj), .s1_is_bj(s1_is_bj), .s0_is_ls(s0_is_ls), .s1_is_ls(s1_is_ls),
        .s0_is_hm(s0_is_hm), .s1_is_hm(s1_is_hm),
        .s0_is_single(s0_is_single), .s1_is_single(s1_is_single),
        .o_valid(o_valid), .o_pc0(o_pc0), .o_pc1(o_pc1), .o_inst0(o_inst0), .o_inst1(o_inst1),
        .perf_dual_cnt(perf_dual_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [1:0]  ov;
        logic [31:0] p0, i0, p1, i1;
        int          cnt;
        logic [31:0] qi0, qi1;
    } exp_t;

    ent_t        mq[$];
    exp_t        exp_q[$];
    logic [1:0]  ev;
    logic [31:0] ep0, ei0, ep1, ei1;
    int          m_dual, m_stall;
    int          n_cmp, n_err;
    logic [31:0] pc_seq;

    function automatic logic [1:0] model_n(input int cnt);
        logic blk;
        if (flush || id_stall || cnt == 0) return 2'd0;
        if (s0_is_bj && cnt < 2) return 2'd0;
        blk = (cnt < 2) || s1_is_bj || s0_is_single || s1_is_single
           || (s0_is_ls && s1_is_ls) || (s0_is_hm && s1_is_hm)
           || (s0_w_reg_ena && (s0_w_reg_dst == s1_rs || s0_w_reg_dst == s1_rt))
           || (s0_w_reg_ena && s1_w_reg_ena && s0_w_reg_dst == s1_w_reg_dst);
        return blk ? 2'd1 : 2'd2;
    endfunction

    task automatic clear_flags();
        s0_w_reg_ena = 0; s1_w_reg_ena = 0;
        s0_w_reg_dst = 5'd0; s1_rs = 5'd0; s1_rt = 5'd0; s1_w_reg_dst = 5'd0;
        s0_is_bj = 0; s1_is_bj = 0; s0_is_ls = 0; s1_is_ls = 0;
        s0_is_hm = 0; s1_is_hm = 0; s0_is_single = 0; s1_is_single = 0;
        // distinct non-zero fields so that no accidental RAW/WAW is seen
        s0_w_reg_dst = 5'd9; s1_rs = 5'd10; s1_rt = 5'd11; s1_w_reg_dst = 5'd12;
    endtask

    task automatic fetch(input logic [1:0] v);
        if_valid = v;
        if_pc0 = pc_seq; if_pc1 = pc_seq + 32'd4;
        if_inst0 = $urandom; if_inst1 = $urandom;
        pc_seq = pc_seq + 32'd8;
    endtask

    // Predict the coming edge, queue the expectation, then pop and compare after the edge.
    task automatic tick();
        int cnt;
        logic [1:0] n;
        exp_t e;
        ent_t t;
        cnt = mq.size();
        n = model_n(cnt);
        if (n == 2'd2) m_dual++;
        if (!flush && !id_stall && cnt >= 1 && n == 2'd0) m_stall++;
        if (flush) begin
            mq.delete();
            ev = 2'b00;
        end else begin
            if (!id_stall) begin
                ev = {n == 2'd2, n != 2'd0};
                if (n != 2'd0) begin ep0 = mq[0].pc; ei0 = mq[0].inst; end
                if (n == 2'd2) begin ep1 = mq[1].pc; ei1 = mq[1].inst; end
                for (int k = 0; k < int'(n); k++) t = mq.pop_front();
            end
            if (DEPTH - cnt >= 2) begin
                if (if_valid[0]) mq.push_back('{if_pc0, if_inst0});
                if (if_valid == 2'b11) mq.push_back('{if_pc1, if_inst1});
            end
        end
        e.ov = ev; e.p0 = ep0; e.i0 = ei0; e.p1 = ep1; e.i1 = ei1;
        e.cnt = mq.size(); e.qi0 = '0; e.qi1 = '0;
        if (mq.size() >= 1) e.qi0 = mq[0].inst;
        if (mq.size() >= 2) e.qi1 = mq[1].inst;
        exp_q.push_back(e);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++; if (o_valid !== e.ov) begin n_err++; $display("FAIL o_valid: got %b expected %b @%0t", o_valid, e.ov, $time); end
        if (e.ov[0]) begin
            n_cmp++; if (o_pc0 !== e.p0) begin n_err++; $display("FAIL o_pc0: got %h expected %h @%0t", o_pc0, e.p0, $time); end
            n_cmp++; if (o_inst0 !== e.i0) begin n_err++; $display("FAIL o_inst0: got %h expected %h @%0t", o_inst0, e.i0, $time); end
        end
        if (e.ov[1]) begin
            n_cmp++; if (o_pc1 !== e.p1) begin n_err++; $display("FAIL o_pc1: got %h expected %h @%0t", o_pc1, e.p1, $time); end
            n_cmp++; if (o_inst1 !== e.i1) begin n_err++; $display("FAIL o_inst1: got %h expected %h @%0t", o_inst1, e.i1, $time); end
        end
        n_cmp++; if (q_valid !== {e.cnt >= 2, e.cnt >= 1}) begin n_err++; $display("FAIL q_valid: got %b expected count %0d @%0t", q_valid, e.cnt, $time); end
        n_cmp++; if (iq_ready !== (DEPTH - e.cnt >= 2)) begin n_err++; $display("FAIL iq_ready: got %b expected count %0d @%0t", iq_ready, e.cnt, $time); end
        if (e.cnt >= 1) begin
            n_cmp++; if (q_inst0 !== e.qi0) begin n_err++; $display("FAIL q_inst0: got %h expected %h @%0t", q_inst0, e.qi0, $time); end
        end
        if (e.cnt >= 2) begin
            n_cmp++; if (q_inst1 !== e.qi1) begin n_err++; $display("FAIL q_inst1: got %h expected %h @%0t", q_inst1, e.qi1, $time); end
        end
    endtask

    task automatic model_reset();
        mq.delete(); exp_q.delete();
        ev = 2'b00; ep0 = '0; ei0 = '0; ep1 = '0; ei1 = '0;
        m_dual = 0; m_stall = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 0; id_stall = 0; if_valid = 2'b00;
        if_pc0 = '0; if_pc1 = '0; if_inst0 = '0; if_inst1 = '0;
        clear_flags();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (o_valid !== 2'b00) begin n_err++; $display("FAIL reset o_valid: got %b expected 00", o_valid); end
        n_cmp++; if (q_valid !== 2'b00) begin n_err++; $display("FAIL reset q_valid: got %b expected 00", q_valid); end
        n_cmp++; if (iq_ready !== 1'b1) begin n_err++; $display("FAIL reset iq_ready: got %b expected 1", iq_ready); end
        n_cmp++; if ({o_pc0, o_pc1, o_inst0, o_inst1} !== 128'd0) begin n_err++; $display("FAIL reset payload: got %h/%h expected 0", o_pc0, o_inst0); end
        n_cmp++; if ({perf_dual_cnt, perf_stall_cnt} !== 64'd0) begin n_err++; $display("FAIL reset perf: got %0d/%0d expected 0", perf_dual_cnt, perf_stall_cnt); end
        resetn = 1'b1;
    endtask

    task automatic test_dual();
        if_valid = 2'b11;
        if_pc0 = 32'h0000_0100; if_inst0 = 32'h0043_0821;
        if_pc1 = 32'h0000_0104; if_inst1 = 32'h00a6_2021;
        tick();
        n_cmp++; if (q_valid !== 2'b11) begin n_err++; $display("FAIL dual q_valid: got %b expected 11", q_valid); end
        if_valid = 2'b00;
        tick();
        n_cmp++; if (o_valid !== 2'b11 || o_pc0 !== 32'h100 || o_pc1 !== 32'h104) begin
            n_err++; $display("FAIL dual issue: got %b %h %h expected 11 100 104", o_valid, o_pc0, o_pc1);
        end
        fetch(2'b10);
        tick();
        n_cmp++; if (q_valid !== 2'b00) begin n_err++; $display("FAIL lane1-only ignored q_valid: got %b expected 00", q_valid); end
    endtask

    task automatic test_raw();
        logic [31:0] second;
        fetch(2'b11);
        second = if_inst1;
        tick();
        if_valid = 2'b00;
        s0_w_reg_ena = 1; s0_w_reg_dst = 5'd1; s1_rs = 5'd1;
        tick();
        n_cmp++; if (o_valid !== 2'b01) begin n_err++; $display("FAIL raw split: got %b expected 01", o_valid); end
        clear_flags();
        tick();
        n_cmp++; if (o_inst0 !== second) begin n_err++; $display("FAIL raw next: got %h expected %h", o_inst0, second); end
    endtask

    task automatic test_branch();
        fetch(2'b01);
        tick();
        if_valid = 2'b00; s0_is_bj = 1;
        tick();
        n_cmp++; if (o_valid !== 2'b00) begin n_err++; $display("FAIL branch wait: got %b expected 00", o_valid); end
        fetch(2'b01);
        tick();
        if_valid = 2'b00;
        tick();
        n_cmp++; if (o_valid !== 2'b11) begin n_err++; $display("FAIL branch pair: got %b expected 11", o_valid); end
        clear_flags();
    endtask

    task automatic test_hazards();
        for (int k = 0; k < 10; k++) begin
            clear_flags();
            fetch(2'b11);
            tick();
            if_valid = 2'b00;
            case (k)
                0: s1_is_bj = 1;
                1: s0_is_single = 1;
                2: s1_is_single = 1;
                3: begin s0_is_ls = 1; s1_is_ls = 1; end
                4: begin s0_is_hm = 1; s1_is_hm = 1; end
                5: begin s0_w_reg_ena = 1; s0_w_reg_dst = 5'd7; s1_rt = 5'd7; end
                6: begin s0_w_reg_ena = 1; s1_w_reg_ena = 1; s0_w_reg_dst = 5'd3; s1_w_reg_dst = 5'd3; end
                7: s0_is_ls = 1;
                8: begin s0_is_bj = 1; s0_is_hm = 1; s1_is_hm = 1; end
                default: begin s0_w_reg_ena = 1; s1_w_reg_ena = 1; end
            endcase
            tick();
            clear_flags();
            tick();
        end
    endtask

    task automatic test_full_wrap();
        id_stall = 1;
        for (int k = 0; k < 3; k++) begin fetch(2'b11); tick(); end
        fetch(2'b01);
        tick();
        n_cmp++; if (iq_ready !== 1'b0) begin n_err++; $display("FAIL full iq_ready: got %b expected 0", iq_ready); end
        fetch(2'b11);
        tick();
        id_stall = 0; if_valid = 2'b00;
        for (int k = 0; k < 5; k++) tick();
        n_cmp++; if (q_valid !== 2'b00) begin n_err++; $display("FAIL drain q_valid: got %b expected 00", q_valid); end
    endtask

    task automatic test_stall_flush();
        fetch(2'b11); tick();
        fetch(2'b11); tick();
        if_valid = 2'b00; id_stall = 1;
        repeat (3) tick();
        n_cmp++; if (q_valid !== 2'b11) begin n_err++; $display("FAIL stall count: got %b expected 11", q_valid); end
        flush = 1;
        fetch(2'b11);
        tick();
        n_cmp++; if (o_valid !== 2'b00 || q_valid !== 2'b00) begin
            n_err++; $display("FAIL flush: got o_valid %b q_valid %b expected 00 00", o_valid, q_valid);
        end
        flush = 0; id_stall = 0; if_valid = 2'b00;
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] want_d, want_s;
`ifdef ISSUE_PERF_CNT_EN
        want_d = 32'(m_dual); want_s = 32'(m_stall);
`else
        want_d = 32'd0; want_s = 32'd0;
`endif
        n_cmp++; if (perf_dual_cnt !== want_d) begin n_err++; $display("FAIL perf_dual_cnt: got %0d expected %0d", perf_dual_cnt, want_d); end
        n_cmp++; if (perf_stall_cnt !== want_s) begin n_err++; $display("FAIL perf_stall_cnt: got %0d expected %0d", perf_stall_cnt, want_s); end
    endtask

    task automatic test_async_reset();
        fetch(2'b11); tick();
        fetch(2'b11); tick();
        #3 resetn = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 2'b00 || q_valid !== 2'b00) begin
            n_err++; $display("FAIL async reset: got o_valid %b q_valid %b expected 00 00", o_valid, q_valid);
        end
        n_cmp++; if (o_pc0 !== 32'd0 || perf_dual_cnt !== 32'd0) begin
            n_err++; $display("FAIL async reset regs: got %h %0d expected 0 0", o_pc0, perf_dual_cnt);
        end
        model_reset();
        if_valid = 2'b00;
        @(posedge clk); #1;
        resetn = 1'b1;
        fetch(2'b11); tick();
        if_valid = 2'b00; tick();
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        pc_seq = 32'h0000_1000;
        test_reset();
        test_dual();
        test_raw();
        test_branch();
        test_hazards();
        test_full_wrap();
        test_stall_flush();
        test_perf();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Dual-issue front-end controller between fetch and the two decode slots.
- Buffers fetched instructions in a circular queue and presents the two oldest entries to two external decode-stage-1 instances.
- Takes their decode flags back and decides each cycle whether to issue 0, 1 or 2 instructions into registered decode-slot outputs.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 4.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard queue and issued slots (exception/mispredict)
- id_stall  in  1  downstream not accepting; hold outputs
- if_valid  in  2  fetch lanes valid; bit0 is the older lane
- if_pc0, if_pc1  in  32  fetch PCs
- if_inst0, if_inst1  in  32  fetch instructions
- iq_ready  out  1  queue has >= 2 free entries
- q_valid  out  2  head entries valid (bit0 = oldest)
- q_inst0, q_inst1  out  32  head instructions to the decode instances
- s0_w_reg_ena, s1_w_reg_ena  in  1  slot write enable from decode
- s0_w_reg_dst  in  5  slot0 destination register
- s1_rs, s1_rt, s1_w_reg_dst  in  5  slot1 register fields
- s0_is_bj, s1_is_bj  in  1  is_branch | is_j_imme | is_jr
- s0_is_ls, s1_is_ls  in  1  load/store
- s0_is_hm, s1_is_hm  in  1  is_hilo | is_mul
- s0_is_single, s1_is_single  in  1  cop0 | tlbp/tlbr/tlbwi | cache | reserved-instruction
- o_valid  out  2  registered issued-slot valids
- o_pc0, o_pc1  out  32  issued PCs
- o_inst0, o_inst1  out  32  issued instructions
- perf_dual_cnt, perf_stall_cnt  out  32  performance counters (optional feature)

Behaviour:
- Reset: rd_ptr, wr_ptr and count = 0; o_valid = 0; o_pc* and o_inst* = 0; counters = 0.
- Queue: count width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- iq_ready = (DEPTH - count) >= 2, computed from registered count only.
- Push: when iq_ready, lane0 is written if if_valid[0]; lane1 is written if if_valid == 2'b11.
- if_valid == 2'b10 is ignored entirely.
- Pushes while !iq_ready are dropped; fetch must hold.
- q_valid[0] = count >= 1; q_valid[1] = count >= 2. q_inst0/q_inst1 are the entries at rd_ptr and rd_ptr+1.
- Issue decision is combinational and applies only when !id_stall and !flush; n = number issued.
  - n = 0 when count == 0.
  - n = 0 when s0_is_bj and !q_valid[1]: a branch waits for its delay slot to arrive.
  - Slot1 is blocked by any of:
    - !q_valid[1]
    - s1_is_bj
    - s0_is_single or s1_is_single
    - s0_is_ls & s1_is_ls
    - s0_is_hm & s1_is_hm
    - s0_w_reg_ena & (s0_w_reg_dst == s1_rs | s0_w_reg_dst == s1_rt): RAW
    - s0_w_reg_ena & s1_w_reg_ena & equal destinations: WAW
  - Otherwise n = 2 if slot1 is not blocked, else n = 1.
  - A branch whose delay slot is present but blocked issues alone (n = 1); the delay slot issues next cycle.
- Pop n entries in the same cycle. Push and pop in the same cycle are legal; count_next = count + pushes - n.
- Output registers, 1-cycle latency:
  - When !id_stall: o_valid <= {n==2, n>=1}; o_pc*/o_inst* load from head entries.
  - Unissued slots keep their payload with valid = 0.
  - When id_stall: all outputs hold and nothing pops.
- flush (synchronous, highest priority):
  - Next cycle: count, rd_ptr, wr_ptr = 0; o_valid = 0.
  - Same-cycle pushes and issue are discarded.
  - flush overrides id_stall.
- Reset asserted mid-operation clears everything immediately (asynchronous).

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined:
  - perf_dual_cnt increments on every cycle with n == 2.
  - perf_stall_cnt increments on every cycle with count >= 1, !id_stall, !flush and n == 0.
  - Both counters are 32-bit, wrap at 2^32, and are cleared only by reset.
- Undefined: counter registers are not built; both ports are tied to 0.

Test Plan:
- Reset, then push addu $1,$2,$3 + addu $4,$5,$6 -> next cycle q_valid = 2'b11; cycle after, o_valid = 2'b11 with both PCs in order; count = 0.
- Slot0 writes $1 (s0_w_reg_ena = 1, dst = 1), slot1 has s1_rs = 1 -> o_valid = 2'b01; next cycle slot1's instruction is presented as o_inst0.
- s0_is_bj with count = 1 -> o_valid = 2'b00 and count holds; push the delay slot -> next issue o_valid = 2'b11.
- Fill the queue to DEPTH-1 = 7 -> iq_ready = 0 and pushes are ignored; drain across pointer wrap -> FIFO order preserved.
- id_stall held 3 cycles -> o_* stable and count unchanged; flush asserted during the stall -> next cycle count = 0, o_valid = 0.
- With ISSUE_PERF_CNT_EN: 5 dual-issue cycles and 2 delay-slot-wait cycles -> perf_dual_cnt = 5, perf_stall_cnt = 2. Without it -> both read 0.
